input_conditioner: RTL

- Parametrised, multi-channel successor to the two-flop input synchroniser used on the game's button inputs (pause, new game, up, down).
- Each channel gets a configurable-depth synchroniser, optional polarity inversion, a counter-based debouncer, registered rise/fall pulses, and an optional held-key auto-repeat.
- Sits between the raw pad inputs and the game core. It gives the game clean levels ("pressed" = 1) and single-cycle event pulses, so paddle movement and menu actions no longer rely on raw levels.

---
 rtl/input_conditioner.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/input_conditioner.sv
// input_conditioner: per-channel synchroniser, polarity correction, counter
// debouncer, registered rise/fall pulses and optional held-key auto-repeat.
// Outputs are clean active-high levels plus single-cycle event pulses.
module input_conditioner #(
  parameter int                     CHANNELS        = 4,
  parameter int                     SYNC_STAGES     = 2,
  parameter int                     DEBOUNCE_CYCLES = 4,
  parameter int                     REPEAT_DELAY    = 0,
  parameter int                     REPEAT_PERIOD   = 1,
  parameter logic [CHANNELS-1:0]    INVERT          = {CHANNELS{1'b0}}
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] raw_in,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] press
);

  // Debounce counter never has to hold more than DEBOUNCE_CYCLES-1.
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  // Repeat counter sized for the longer of the two repeat intervals.
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

  // Auto-repeat phase: waiting for the initial delay, or repeating at the period.
  typedef enum logic {
    PH_DELAY  = 1'b0,
    PH_PERIOD = 1'b1
  } phase_t;

  // Synchroniser chain, one vector per stage. Reset loads INVERT so that the
  // corrected value s is 0 ("released") right after reset.
  logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0] s;

  logic [CW-1:0]       cnt_q [CHANNELS];
  logic [CW-1:0]       cnt_d [CHANNELS];
  logic [CHANNELS-1:0] level_d;
  logic [CHANNELS-1:0] rise_d;
  logic [CHANNELS-1:0] fall_d;
  logic [CHANNELS-1:0] rep_d;

  // Shift raw inputs through the synchroniser chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= INVERT;
    end else begin
      sync_q[0] <= raw_in;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1] ^ INVERT;

  // Debounce next-state: count consecutive cycles where s differs from level.
  always_comb begin
    level_d = level;
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_d[i] = '0;
      if (s[i] != level[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          level_d[i] = s[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  assign rise_d = level_d & ~level;
  assign fall_d = ~level_d & level;

  // Debounce counters, level and the registered event pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= '0;
      level <= '0;
      rise  <= '0;
      fall  <= '0;
      press <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= cnt_d[i];
      level <= level_d;
      rise  <= rise_d;
      fall  <= fall_d;
      press <= rise_d | rep_d;
    end
  end

  generate
    if (REPEAT_DELAY > 0) begin : g_repeat
      localparam logic [RW-1:0] DLY_M1 = RW'(REPEAT_DELAY - 1);
      localparam logic [RW-1:0] PER_M1 = RW'(REPEAT_PERIOD - 1);

      phase_t        phase_q [CHANNELS];
      phase_t        phase_d [CHANNELS];
      logic [RW-1:0] rcnt_q  [CHANNELS];
      logic [RW-1:0] rcnt_d  [CHANNELS];

      // Repeat phase and counter registers.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < CHANNELS; i++) begin
            phase_q[i] <= PH_DELAY;
            rcnt_q[i]  <= '0;
          end
        end else begin
          for (int i = 0; i < CHANNELS; i++) begin
            phase_q[i] <= phase_d[i];
            rcnt_q[i]  <= rcnt_d[i];
          end
        end
      end

      // Repeat next-state. The pulse is gated by level_d so a repeat slot that
      // lands on the release edge is dropped: no press accompanies a fall.
      always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
          rep_d[i]   = 1'b0;
          rcnt_d[i]  = '0;
          phase_d[i] = PH_DELAY;
          if (level[i]) begin
            if (rcnt_q[i] == ((phase_q[i] == PH_DELAY) ? DLY_M1 : PER_M1)) begin
              rep_d[i]   = level_d[i];
              phase_d[i] = PH_PERIOD;
            end else begin
              rcnt_d[i]  = rcnt_q[i] + RW'(1);
              phase_d[i] = phase_q[i];
            end
          end
        end
      end
    end else begin : g_no_repeat
      assign rep_d = '0;
    end
  endgenerate

endmodule
